reg_file_rename_mp: RTL and testbench

- Multi-port architectural register file with per-register rename tags, for the tag-based out-of-order core.
- Decode reads source operands as either a ready value or a pending producer tag, and renames the destination to a new tag.
- Multiple writeback buses retire results: data is committed only when the bus tag matches the register's current tag.
- Synchronous successor of the single-read-pair / single-writeback file, adding bypass, a defined collision order and a synchronous flush.

---
 rtl/reg_file_rename_mp_if.sv | 33 +++
 rtl/reg_file_rename_mp.sv | 93 +++++++++
 tb/tb_reg_file_rename_mp.sv | 135 +++++++++++++
 3 files changed

// File: rtl/reg_file_rename_mp_if.sv
// reg_file_rename_mp_if: read, rename and writeback bus of the renaming register file
interface reg_file_rename_mp_if #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int REG_NUM = 32,
    parameter int NUM_RD  = 2,
    parameter int NUM_WB  = 2,
    parameter int AW      = $clog2(REG_NUM)
);
    logic                     flush;
    logic [NUM_RD-1:0]        rs_en;
    logic [NUM_RD*AW-1:0]     rs_addr;
    logic [NUM_RD*DATA_W-1:0] rs_val;
    logic [NUM_RD*TAG_W-1:0]  rs_tag;
    logic [NUM_RD-1:0]        rs_vld;
    logic                     alloc_en;
    logic [AW-1:0]            alloc_rd;
    logic [TAG_W-1:0]         alloc_tag;
    logic [NUM_WB-1:0]        wb_en;
    logic [NUM_WB*AW-1:0]     wb_rd;
    logic [NUM_WB*TAG_W-1:0]  wb_tag;
    logic [NUM_WB*DATA_W-1:0] wb_data;

    modport master (
        output flush, rs_en, rs_addr, alloc_en, alloc_rd, alloc_tag, wb_en, wb_rd, wb_tag, wb_data,
        input  rs_val, rs_tag, rs_vld
    );

    modport slave (
        input  flush, rs_en, rs_addr, alloc_en, alloc_rd, alloc_tag, wb_en, wb_rd, wb_tag, wb_data,
        output rs_val, rs_tag, rs_vld
    );
endinterface

// File: rtl/reg_file_rename_mp.sv
// reg_file_rename_mp: multi-port register file with rename tags, writeback bypass and flush
module reg_file_rename_mp #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int REG_NUM = 32,
    parameter int NUM_RD  = 2,
    parameter int NUM_WB  = 2,
    parameter int AW      = $clog2(REG_NUM)
) (
    input logic clk,
    input logic rst,
    reg_file_rename_mp_if.slave bus
);
    logic [DATA_W-1:0] data_q [REG_NUM];
    logic [TAG_W-1:0]  tag_q  [REG_NUM];
    logic [DATA_W-1:0] data_d [REG_NUM];
    logic [TAG_W-1:0]  tag_d  [REG_NUM];
    logic [AW-1:0]     rs_addr_a [NUM_RD];
    logic [DATA_W-1:0] rd_val [NUM_RD];
    logic [TAG_W-1:0]  rd_tag [NUM_RD];
    logic [AW-1:0]     wb_rd_a [NUM_WB];
    logic [TAG_W-1:0]  wb_tag_a [NUM_WB];
    logic [DATA_W-1:0] wb_data_a [NUM_WB];
    logic [NUM_WB-1:0] wb_hit;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign rs_addr_a[i] = bus.rs_addr[i*AW +: AW];
    end

    // A writeback matches only when its tag is the register's live (pre-update) producer tag
    for (genvar j = 0; j < NUM_WB; j++) begin : g_wb
        assign wb_rd_a[j]   = bus.wb_rd[j*AW +: AW];
        assign wb_tag_a[j]  = bus.wb_tag[j*TAG_W +: TAG_W];
        assign wb_data_a[j] = bus.wb_data[j*DATA_W +: DATA_W];
        assign wb_hit[j]    = bus.wb_en[j] && wb_tag_a[j] != '0 && wb_tag_a[j] == tag_q[wb_rd_a[j]];
    end

    // Read lookup with writeback bypass; descending scan lets the lowest matching port win
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_val[i] = data_q[rs_addr_a[i]];
            rd_tag[i] = tag_q[rs_addr_a[i]];
            for (int j = NUM_WB - 1; j >= 0; j--) begin
                if (wb_hit[j] && wb_rd_a[j] == rs_addr_a[i]) begin
                    rd_val[i] = wb_data_a[j];
                    rd_tag[i] = '0;
                end
            end
        end
    end

    // Next state: wb commit, then alloc overrides the tag clear, then flush clears all tags; x0 pinned
    always_comb begin
        for (int r = 0; r < REG_NUM; r++) begin
            data_d[r] = data_q[r];
            tag_d[r]  = tag_q[r];
        end
        for (int j = NUM_WB - 1; j >= 0; j--) begin
            if (wb_hit[j]) begin
                data_d[wb_rd_a[j]] = wb_data_a[j];
                tag_d[wb_rd_a[j]]  = '0;
            end
        end
        if (bus.alloc_en && bus.alloc_rd != '0 && bus.alloc_tag != '0 && !bus.flush)
            tag_d[bus.alloc_rd] = bus.alloc_tag;
        if (bus.flush)
            for (int r = 0; r < REG_NUM; r++) tag_d[r] = '0;
        data_d[0] = '0;
        tag_d[0]  = '0;
    end

    // Register file state update
    always_ff @(posedge clk) begin
        for (int r = 0; r < REG_NUM; r++) begin
            data_q[r] <= rst ? '0 : data_d[r];
            tag_q[r]  <= rst ? '0 : tag_d[r];
        end
    end

    // Registered read ports; value and tag hold while the port is idle
    always_ff @(posedge clk) begin
        bus.rs_vld <= rst ? '0 : bus.rs_en;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rst) begin
                bus.rs_val[i*DATA_W +: DATA_W] <= '0;
                bus.rs_tag[i*TAG_W +: TAG_W]   <= '0;
            end else if (bus.rs_en[i]) begin
                bus.rs_val[i*DATA_W +: DATA_W] <= rd_val[i];
                bus.rs_tag[i*TAG_W +: TAG_W]   <= rd_tag[i];
            end
        end
    end
endmodule

// File: tb/tb_reg_file_rename_mp.sv
// tb_reg_file_rename_mp: directed scoreboard bench for the renaming register file
module tb_reg_file_rename_mp;
    typedef struct {
        string       n;
        int          p;
        logic [31:0] v;
        logic [3:0]  t;
    } exp_t;

    logic clk = 0;
    logic rst = 0;
    int   checks = 0;
    int   errs = 0;
    exp_t q[$];

    reg_file_rename_mp_if bus ();
    reg_file_rename_mp dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(string n, logic [63:0] o, logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errs++;
            $error("FAIL %s got %0h exp %0h", n, o, e);
        end
    endtask

    task automatic idle();
        bus.flush = 0;
        bus.rs_en = '0;
        bus.rs_addr = '0;
        bus.alloc_en = 0;
        bus.alloc_rd = '0;
        bus.alloc_tag = '0;
        bus.wb_en = '0;
        bus.wb_rd = '0;
        bus.wb_tag = '0;
        bus.wb_data = '0;
    endtask

    task automatic rd(int p, int a, logic [31:0] v, logic [3:0] t, string n);
        bus.rs_en[p] = 1'b1;
        bus.rs_addr[p*5 +: 5] = 5'(a);
        q.push_back('{n, p, v, t});
    endtask

    task automatic al(int r, int t);
        bus.alloc_en = 1;
        bus.alloc_rd = 5'(r);
        bus.alloc_tag = 4'(t);
    endtask

    task automatic wb(int p, int r, int t, logic [31:0] d);
        bus.wb_en[p] = 1'b1;
        bus.wb_rd[p*5 +: 5] = 5'(r);
        bus.wb_tag[p*4 +: 4] = 4'(t);
        bus.wb_data[p*32 +: 32] = d;
    endtask

    task automatic step();
        logic [1:0] ev;
        exp_t e;
        ev = rst ? 2'b00 : bus.rs_en;
        @(posedge clk);
        #1;
        chk("rs_vld", 64'(bus.rs_vld), 64'(ev));
        while (q.size() > 0) begin
            e = q.pop_front();
            chk({e.n, "_val"}, 64'(bus.rs_val[e.p*32 +: 32]), 64'(e.v));
            chk({e.n, "_tag"}, 64'(bus.rs_tag[e.p*4 +: 4]), 64'(e.t));
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        step();
        rst = 0;
        chk("rst_val", 64'(bus.rs_val), 64'd0);
        chk("rst_tag", 64'(bus.rs_tag), 64'd0);
        rd(0, 5, 0, 0, "x5_reset"); rd(1, 0, 0, 0, "x0_reset"); step();

        al(3, 7); step();
        rd(0, 3, 0, 7, "x3_pending"); step();
        wb(0, 3, 7, 32'hDEADBEEF); step();
        rd(0, 3, 32'hDEADBEEF, 0, "x3_ready"); step();
        step();
        chk("hold_val", 64'(bus.rs_val[31:0]), 64'hDEADBEEF);

        al(4, 2); step();
        al(4, 9); step();
        wb(1, 4, 2, 32'h11); step();
        rd(0, 4, 0, 9, "x4_stale"); step();
        wb(1, 4, 9, 32'h22); step();
        rd(1, 4, 32'h22, 0, "x4_ready"); step();

        al(6, 5); step();
        rd(0, 6, 32'h55, 0, "x6_bypass"); wb(1, 6, 5, 32'h55); al(6, 8); step();
        rd(0, 6, 32'h55, 8, "x6_realloc"); step();
        rd(1, 6, 32'h55, 8, "x6_old_tag"); al(6, 10); step();
        rd(0, 6, 32'h55, 10, "x6_new_tag"); step();

        al(9, 3); step();
        wb(0, 9, 3, 32'hA); wb(1, 9, 3, 32'hB); rd(0, 9, 32'hA, 0, "x9_dual_byp"); step();
        rd(0, 9, 32'hA, 0, "x9_low_wins"); step();

        al(10, 5); step();
        al(10, 0); step();
        rd(1, 10, 0, 5, "x10_tag0_noop"); step();
        wb(0, 0, 0, 32'h99); al(0, 2); step();
        rd(0, 0, 0, 0, "x0_ignored"); step();

        al(1, 1); step();
        al(2, 2); step();
        al(3, 3); step();
        bus.flush = 1; al(7, 4); wb(0, 2, 2, 32'h222); rd(1, 1, 0, 1, "x1_preflush"); step();
        rd(0, 1, 0, 0, "x1_flushed"); rd(1, 2, 32'h222, 0, "x2_flush_wb"); step();
        rd(0, 3, 32'hDEADBEEF, 0, "x3_flushed"); rd(1, 7, 0, 0, "x7_flush_alloc"); step();
        rd(0, 6, 32'h55, 0, "x6_flushed"); rd(1, 4, 32'h22, 0, "x4_kept"); step();

        al(8, 2); step();
        rst = 1; al(8, 3); wb(0, 8, 2, 32'h77); bus.rs_en = 2'b11; step();
        rst = 0;
        chk("midrst_val", 64'(bus.rs_val), 64'd0);
        chk("midrst_tag", 64'(bus.rs_tag), 64'd0);
        rd(0, 8, 0, 0, "x8_after_rst"); rd(1, 3, 0, 0, "x3_after_rst"); step();
        al(0, 3); step();
        rd(0, 0, 0, 0, "x0_after_rst"); step();

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
